serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial two's-complement subtractor that computes `diff = a - b - bin` one bit per clock, LSB first. It uses a single full-subtractor stage and a registered borrow. It is the sequential, inverse-operation counterpart of the gate-level ripple-carry adder: it trades latency for area and runs under a start/done handshake. A controller issues operands with `start` and collects `diff`/`bout` on the `done` pulse.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.

Ports:
- `clk` — input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n` — input, 1 bit. Reset is asynchronous and active-low.
- `start` — input, 1 bit. Request; sampled only in IDLE.
- `a` — input, WIDTH bits. Minuend; sampled with `start`.
- `b` — input, WIDTH bits. Subtrahend; sampled with `start`.
- `bin` — input, 1 bit. Borrow-in; sampled with `start`.
- `busy` — output, 1 bit. High while in RUN.
- `done` — output, 1 bit. One-cycle pulse when the result is valid.
- `diff` — output, WIDTH bits. Result; holds its value until the next completion.
- `bout` — output, 1 bit. Final borrow-out (1 means `a < b + bin`, unsigned); held like `diff`.
- `ovf` — output, 1 bit. Signed overflow; present only with `SUB_OVF_EN`.

## Operation
- Internal registers:
  - `sa` and `sb`: operand shift registers, shifted right each RUN cycle.
  - `br`: borrow.
  - `acc`: result shift register; new bits enter at the MSB.
  - `cnt`: bit counter, `$clog2(WIDTH)+1` bits.
- States:
  - IDLE: `start=1` latches `a→sa`, `b→sb`, `bin→br`, clears `cnt`, and moves to RUN. Otherwise IDLE holds.
  - RUN: each cycle computes `d = sa[0]^sb[0]^br` and `br ← (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)`. `d` shifts into `acc[WIDTH-1]`, `sa`/`sb` shift right, and `cnt` increments. On the cycle where `cnt==WIDTH-1`, the state moves to DONE. On that same edge, `diff ← {d, acc[WIDTH-1:1]}` and `bout ← br_next`.
  - DONE: `done=1` for exactly one cycle, then the state returns to IDLE unconditionally.
- `start` is ignored in RUN and DONE; the in-flight operation is never disturbed.
- Arithmetic is modulo 2^WIDTH. `bout` is the unsigned borrow out of the MSB.
- `diff` and `bout` change only on the edge entering DONE, never mid-operation.
- Reset (asserted at any time, including mid-RUN) immediately forces:
  - state to IDLE;
  - `busy=0`, `done=0`, `diff=0`, `bout=0`, `ovf=0`;
  - `sa`, `sb`, `acc`, `br`, `cnt` to 0.
  - The partial result is discarded. The first `start` after reset deassertion is accepted normally.

## Timing
- Edge E0 samples `start=1` in IDLE.
- `busy` is high after E0 through edge E(WIDTH).
- Edges E1..E(WIDTH) process bits 0..WIDTH-1.
- After E(WIDTH): `busy=0`, `done=1`, and `diff`/`bout` are valid.
- After E(WIDTH+1): `done=0`, state is IDLE.
- Latency from the start-sampling edge to `done` is WIDTH cycles. Throughput is one operation per WIDTH+2 cycles.
- `busy` and `done` are never high together. All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `SUB_OVF_EN` defined:
  - Adds the `ovf` output port.
  - The MSBs `a[WIDTH-1]` and `b[WIDTH-1]` are latched at start.
  - On the edge entering DONE, `ovf ← (a_msb != b_msb) && (d_msb != a_msb)`, where `d_msb` is the final result MSB.
  - `ovf` holds like `diff` and resets to 0.
- `SUB_OVF_EN` undefined: no `ovf` port, no extra registers. All other behaviour is identical.

## Test plan
- `a=0x05`, `b=0x03`, `bin=0` → `diff=0x02`, `bout=0`; `done` rises exactly 8 edges after start sampled; `busy` high for 8 cycles.
- `a=0x03`, `b=0x05`, `bin=0` → `diff=0xFE`, `bout=1`. Then `a=0x00`, `b=0x00`, `bin=1` → `diff=0xFF`, `bout=1`.
- `a=0x80`, `b=0x01`, `bin=0` → `diff=0x7F`, `bout=0`, `ovf=1` with `SUB_OVF_EN`. Then `a=0x7F`, `b=0x01` → `ovf=0`.
- Start with `a=0x10`, `b=0x01`; pulse `start` with `a=0xFF`, `b=0xFF` during RUN and during DONE → both ignored; result `diff=0x0F`; `diff` unchanged until that `done`.
- Assert `rst_n=0` after 4 RUN edges of `a=0xAA`, `b=0x55` → all outputs 0 immediately. Release reset, start `a=0x01`, `b=0x01` → `diff=0x00`, `bout=0` after 8 cycles.
- Back-to-back: issue `start` in the first IDLE cycle after each `done` for 3 operations → each completes in WIDTH cycles, with results matching `a - b - bin` mod 256.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor stage with registered borrow.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb, acc;
  logic [CW-1:0] cnt;
  logic br, d, br_nx, last;
`ifdef SUB_OVF_EN
  logic a_msb, b_msb;
`endif
  always_comb begin
    d = sa[0] ^ sb[0] ^ br;
    br_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    last = cnt == CW'(WIDTH - 1);
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      acc <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        sa <= a;
        sb <= b;
        br <= bin;
        cnt <= '0;
`ifdef SUB_OVF_EN
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
`endif
      end else if (state == RUN) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        br <= br_nx;
        acc <= {d, acc[WIDTH-1:1]};
        cnt <= cnt + CW'(1);
        if (last) begin
          diff <= {d, acc[WIDTH-1:1]};
          bout <= br_nx;
`ifdef SUB_OVF_EN
          ovf <= (a_msb != b_msb) && (d != a_msb);
`endif
        end
      end
    end
  end
endmodule
